pipeline_hazard_ctrl: RTL and testbench

// - Sequences the 5-stage RV32I pipeline around the instruction decoder.
// - Consumes decoder outputs (type one-hot, load flag) plus raw instruction fields in ID.
// - Tracks in-flight destination registers in an EX/MEM/WB scoreboard.
// - Drives stall (IF/ID hold + EX bubble) and flush (IF/ID kill) for RAW hazards and taken branches/jumps.

---
 rtl/rv_pipe_pkg.sv | 33 +++
 rtl/hazard_scoreboard.sv | 57 +++++
 rtl/pipeline_hazard_ctrl.sv | 162 ++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pipe_pkg.sv
// Shared types for the RV32I hazard controller: decoder one-hot codes,
// scoreboard entry layout, FSM states and the register-match helper.
package rv_pipe_pkg;

    localparam logic [5:0] TYPE_R    = 6'b100000;
    localparam logic [5:0] TYPE_I    = 6'b010000;
    localparam logic [5:0] TYPE_S    = 6'b001000;
    localparam logic [5:0] TYPE_B    = 6'b000100;
    localparam logic [5:0] TYPE_J    = 6'b000010;
    localparam logic [5:0] TYPE_U    = 6'b000001;
    localparam logic [5:0] TYPE_NONE = 6'b000000;

    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic       ld;
    } sb_entry_t;

    typedef enum logic {
        RUN,
        FLUSH
    } fsm_t;

    // x0 is hard-wired zero, so a source of x0 never matches anything.
    function automatic logic rs_hit(
        input sb_entry_t  e,
        input logic [4:0] rs,
        input logic       use_rs
    );
        return use_rs && (rs != 5'd0) && e.v && (e.rd == rs);
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// EX/MEM/WB destination scoreboard with rs1/rs2 match against ID.
// Ports: clock, reset (async high), in_entry (ID entry entering EX),
//   rs1/rs2 + use flags from ID, hazard (RAW match, ungated by id_valid).
// Macro FORWARDING_EN: only an EX-stage load can cause a hazard.
module hazard_scoreboard
    import rv_pipe_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  sb_entry_t  in_entry,
    input  logic [4:0] rs1,
    input  logic [4:0] rs2,
    input  logic       use_rs1,
    input  logic       use_rs2,
    output logic       hazard
);

    sb_entry_t ex_q, ex_d;
    sb_entry_t mem_q, mem_d;
    sb_entry_t wb_q, wb_d;

    logic [2:0] hit_vec;
    logic [2:0] hz_mask;

    always_comb begin
        ex_d  = in_entry;
        mem_d = ex_q;
        wb_d  = mem_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end

    // hit_vec = {EX, MEM, WB}; WB writes early in the cycle so it never
    // needs to stall the reader.
    always_comb begin
        hit_vec[2] = rs_hit(ex_q,  rs1, use_rs1) | rs_hit(ex_q,  rs2, use_rs2);
        hit_vec[1] = rs_hit(mem_q, rs1, use_rs1) | rs_hit(mem_q, rs2, use_rs2);
        hit_vec[0] = rs_hit(wb_q,  rs1, use_rs1) | rs_hit(wb_q,  rs2, use_rs2);
`ifdef FORWARDING_EN
        hz_mask = {ex_q.ld, 2'b00};
`else
        hz_mask = 3'b110;
`endif
        hazard = |(hit_vec & hz_mask);
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32I pipeline.
// Ports: clock, reset (async high); ID: id_valid, id_instr, id_type,
//   id_load; EX: ex_redirect. Out: stall, bubble_ex, flush, issue,
//   stall_cnt, flush_cnt (saturating). Macro FORWARDING_EN selects the
//   bypass-aware hazard rule inside hazard_scoreboard.
module pipeline_hazard_ctrl
    import rv_pipe_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [31:0]      id_instr,
    input  logic [5:0]       id_type,
    input  logic             id_load,
    input  logic             ex_redirect,
    output logic             stall,
    output logic             bubble_ex,
    output logic             flush,
    output logic             issue,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [2:0] RELOAD = 3'(FLUSH_CYCLES - 1);
    localparam bit         MULTI  = (FLUSH_CYCLES > 1);

    fsm_t             state_q, state_d;
    logic [2:0]       flush_left_q, flush_left_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic      use_rs1, use_rs2, wr_rd;
    logic      sb_hazard, hazard;
    sb_entry_t in_entry;
    logic      unused_instr_bits;

    assign unused_instr_bits = ^{id_instr[31:25], id_instr[14:12], id_instr[6:0]};

    always_comb begin
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        wr_rd   = 1'b0;
        unique case (1'b1)
            (id_type == TYPE_R): begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                wr_rd   = 1'b1;
            end
            (id_type == TYPE_I): begin
                use_rs1 = 1'b1;
                wr_rd   = 1'b1;
            end
            (id_type == TYPE_S),
            (id_type == TYPE_B): begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            (id_type == TYPE_J),
            (id_type == TYPE_U): begin
                wr_rd = 1'b1;
            end
            default: begin
                // NOP or load: only a load reads rs1 and writes rd.
                use_rs1 = id_load;
                wr_rd   = id_load;
            end
        endcase
    end

    hazard_scoreboard u_sb (
        .clock    (clock),
        .reset    (reset),
        .in_entry (in_entry),
        .rs1      (id_instr[19:15]),
        .rs2      (id_instr[24:20]),
        .use_rs1  (use_rs1),
        .use_rs2  (use_rs2),
        .hazard   (sb_hazard)
    );

    assign hazard = id_valid & sb_hazard;

    always_comb begin
        state_d      = state_q;
        flush_left_d = flush_left_q;
        stall        = 1'b0;
        bubble_ex    = 1'b0;
        flush        = 1'b0;
        issue        = 1'b0;
        // Outputs are forced low while reset is held, not just after it.
        if (!reset) begin
            unique case (state_q)
                RUN: begin
                    if (ex_redirect) begin
                        flush     = 1'b1;
                        bubble_ex = 1'b1;
                        if (MULTI) begin
                            state_d      = FLUSH;
                            flush_left_d = RELOAD;
                        end
                    end else if (hazard) begin
                        stall     = 1'b1;
                        bubble_ex = 1'b1;
                    end else begin
                        issue = id_valid;
                    end
                end
                FLUSH: begin
                    flush     = 1'b1;
                    bubble_ex = 1'b1;
                    if (ex_redirect) begin
                        flush_left_d = RELOAD;
                    end else begin
                        flush_left_d = flush_left_q - 3'd1;
                        if (flush_left_q == 3'd1) begin
                            state_d = RUN;
                        end
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_comb begin
        in_entry.v  = issue & wr_rd;
        in_entry.rd = id_instr[11:7];
        in_entry.ld = issue & id_load;
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (ex_redirect && !(&flush_cnt_q)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= RUN;
            flush_left_q <= 3'd0;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            flush_left_q <= flush_left_d;
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed + random bench for pipeline_hazard_ctrl against a cycle-age
// model of in-flight producers and a flush-window end time.
module tb_pipeline_hazard_ctrl;
    import rv_pipe_pkg::*;

    localparam int FC = 2;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;
`ifdef FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          id_valid = 1'b0;
    logic [31:0]   id_instr = '0;
    logic [5:0]    id_type = '0;
    logic          id_load = 1'b0;
    logic          ex_redirect = 1'b0;
    logic          stall, bubble_ex, flush, issue;
    logic [CW-1:0] stall_cnt, flush_cnt;

    always #5 clock = ~clock;

    pipeline_hazard_ctrl #(
        .FLUSH_CYCLES (FC),
        .CNT_W        (CW)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .id_valid    (id_valid),
        .id_instr    (id_instr),
        .id_type     (id_type),
        .id_load     (id_load),
        .ex_redirect (ex_redirect),
        .stall       (stall),
        .bubble_ex   (bubble_ex),
        .flush       (flush),
        .issue       (issue),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
    );

    int errors = 0;
    int checks = 0;

    // A producer is in EX one cycle after it issued, MEM after two.
    typedef struct {
        int rd;
        bit ld;
        int cyc;
    } prod_t;

    prod_t prods[$];
    int    now = 0;
    int    flush_end = -100;
    int    m_stall_cnt = 0;
    int    m_flush_cnt = 0;
    bit    e_stall, e_bubble, e_flush, e_issue;
    logic  o_stall, o_flush, o_issue;

    logic [5:0] types [7] = '{TYPE_R, TYPE_I, TYPE_S, TYPE_B,
                              TYPE_J, TYPE_U, TYPE_NONE};

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void decode(input logic [5:0] t, input logic ld,
                                   output bit u1, output bit u2,
                                   output bit wr);
        u1 = (t == TYPE_R) || (t == TYPE_I) || (t == TYPE_S) ||
             (t == TYPE_B) || (t == TYPE_NONE && ld);
        u2 = (t == TYPE_R) || (t == TYPE_S) || (t == TYPE_B);
        wr = (t == TYPE_R) || (t == TYPE_I) || (t == TYPE_J) ||
             (t == TYPE_U) || (t == TYPE_NONE && ld);
    endfunction

    function automatic void model_reset();
        prods.delete();
        flush_end   = -100;
        m_stall_cnt = 0;
        m_flush_cnt = 0;
    endfunction

    function automatic void expect_now();
        bit u1, u2, wr, hz, near;
        int rs1, rs2, age;
        e_stall = 0;
        e_bubble = 0;
        e_flush = 0;
        e_issue = 0;
        if (!reset) begin
            decode(id_type, id_load, u1, u2, wr);
            rs1 = int'(id_instr[19:15]);
            rs2 = int'(id_instr[24:20]);
            hz = 0;
            if (id_valid) begin
                foreach (prods[i]) begin
                    age = now - prods[i].cyc;
                    near = FWD ? (age == 1 && prods[i].ld)
                               : (age == 1 || age == 2);
                    if (near && prods[i].rd != 0 &&
                        ((u1 && rs1 == prods[i].rd) ||
                         (u2 && rs2 == prods[i].rd)))
                        hz = 1;
                end
            end
            e_flush  = ex_redirect || (now <= flush_end);
            e_bubble = e_flush || hz;
            e_stall  = !e_flush && hz;
            e_issue  = !e_flush && !hz && id_valid;
        end
    endfunction

    task automatic step();
        bit u1, u2, wr;
        @(negedge clock);
        expect_now();
        o_stall = stall;
        o_flush = flush;
        o_issue = issue;
        chk("stall", stall, e_stall);
        chk("bubble_ex", bubble_ex, e_bubble);
        chk("flush", flush, e_flush);
        chk("issue", issue, e_issue);
        chk("stall_cnt", stall_cnt, m_stall_cnt);
        chk("flush_cnt", flush_cnt, m_flush_cnt);
        @(posedge clock);
        if (reset) begin
            model_reset();
        end else begin
            decode(id_type, id_load, u1, u2, wr);
            if (e_issue && wr)
                prods.push_back('{rd: int'(id_instr[11:7]),
                                  ld: id_load, cyc: now});
            if (ex_redirect) begin
                flush_end = now + FC - 1;
                if (m_flush_cnt < CMAX) m_flush_cnt++;
            end
            if (e_stall && m_stall_cnt < CMAX) m_stall_cnt++;
        end
        now++;
        while (prods.size() > 0 && now - prods[0].cyc > 3)
            void'(prods.pop_front());
        #1;
    endtask

    task automatic set_id(input logic [5:0] t, input logic ld,
                          input int rd, input int rs1, input int rs2);
        id_valid = 1'b1;
        id_type  = t;
        id_load  = ld;
        id_instr = {7'd0, 5'(rs2), 5'(rs1), 3'd0, 5'(rd), 7'h33};
    endtask

    task automatic until_issue(input string tag);
        int n = 0;
        do begin
            step();
            n++;
        end while (!o_issue && n < 6);
        chk(tag, o_issue, 1'b1);
    endtask

    initial begin
        // Reset state.
        #1;
        chk("rst_stall", stall, 1'b0);
        chk("rst_flush", flush, 1'b0);
        chk("rst_cnt", stall_cnt, '0);
        step();
        step();
        reset = 1'b0;

        // Load-use: lw x5 then add x6,x5,x1.
        set_id(TYPE_NONE, 1'b1, 5, 2, 0);
        step();
        set_id(TYPE_R, 1'b0, 6, 5, 1);
        until_issue("load_use_issue");
        chk("load_use_cnt", stall_cnt, FWD ? 1 : 2);

        // ALU producer: addi x3 then sub x4,x3,x3.
        set_id(TYPE_I, 1'b0, 3, 0, 0);
        step();
        set_id(TYPE_R, 1'b0, 4, 3, 3);
        until_issue("alu_use_issue");
        chk("alu_use_cnt", stall_cnt, FWD ? 1 : 4);

        // x0 producer and LUI that reads nothing.
        set_id(TYPE_I, 1'b0, 0, 1, 0);
        step();
        set_id(TYPE_R, 1'b0, 8, 0, 0);
        step();
        chk("x0_issue", o_issue, 1'b1);
        set_id(TYPE_R, 1'b0, 7, 1, 1);
        step();
        set_id(TYPE_U, 1'b0, 7, 7, 7);
        step();
        chk("lui_issue", o_issue, 1'b1);
        chk("nouse_cnt", stall_cnt, FWD ? 1 : 4);

        // Single redirect with a pending hazard in ID.
        set_id(TYPE_I, 1'b0, 9, 1, 0);
        step();
        set_id(TYPE_R, 1'b0, 10, 9, 9);
        ex_redirect = 1'b1;
        step();
        chk("redir_flush0", o_flush, 1'b1);
        ex_redirect = 1'b0;
        step();
        chk("redir_flush1", o_flush, 1'b1);
        chk("redir_nostall", o_stall, 1'b0);
        step();
        chk("redir_done", o_flush, 1'b0);
        chk("redir_cnt", flush_cnt, 1);

        // Back-to-back redirects.
        id_valid = 1'b0;
        ex_redirect = 1'b1;
        step();
        step();
        ex_redirect = 1'b0;
        step();
        chk("b2b_hold", o_flush, 1'b1);
        step();
        chk("b2b_done", o_flush, 1'b0);
        chk("b2b_cnt", flush_cnt, 3);

        // Reset in the middle of a flush with a full scoreboard.
        set_id(TYPE_R, 1'b0, 2, 1, 1);
        step();
        set_id(TYPE_R, 1'b0, 3, 1, 1);
        step();
        set_id(TYPE_R, 1'b0, 4, 1, 1);
        step();
        set_id(TYPE_R, 1'b0, 1, 2, 3);
        ex_redirect = 1'b1;
        step();
        reset = 1'b1;
        model_reset();
        #1;
        chk("midrst_flush", flush, 1'b0);
        chk("midrst_issue", issue, 1'b0);
        chk("midrst_bubble", bubble_ex, 1'b0);
        chk("midrst_fcnt", flush_cnt, '0);
        step();
        reset = 1'b0;
        ex_redirect = 1'b0;
        step();
        chk("postrst_issue", o_issue, 1'b1);
        chk("postrst_stall", o_stall, 1'b0);

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            int ti;
            ti = int'($urandom_range(0, 6));
            set_id(types[ti], (ti == 6) && ($urandom_range(0, 1) == 1),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 3)));
            id_valid = ($urandom_range(0, 7) != 0);
            ex_redirect = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 99) == 0) begin
                reset = 1'b1;
                model_reset();
            end else begin
                reset = 1'b0;
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
